// File: rtl/alarm_sequencer.sv
// Turns one-cycle food/game-over events into timed tone-enable patterns.
// Durations are counted in ticks of a TICK_DIV prescaler that restarts with every pattern.
module alarm_sequencer #(
  parameter int TICK_DIV  = 100000,
  parameter int EAT_ON_MS = 80,
  parameter int GO_ON_MS  = 200,
  parameter int GO_OFF_MS = 150,
  parameter int GO_BEEPS  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic food_eaten,
  input  logic game_over,
  input  logic mute,
  output logic Alarm,
  output logic busy
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, EAT_ON, GO_ON, GO_OFF} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [15:0]   units, units_n, limit;
  logic [3:0]    beeps, beeps_n;
  logic          tick, done;

  assign tick = (presc == PW'(TICK_DIV - 1));
  assign done = tick && (units == limit);

  always_comb begin
    limit = 16'd0;
    case (state)
      EAT_ON:  limit = 16'(EAT_ON_MS - 1);
      GO_ON:   limit = 16'(GO_ON_MS - 1);
      GO_OFF:  limit = 16'(GO_OFF_MS - 1);
      default: limit = 16'd0;
    endcase
  end

  always_comb begin
    state_n = state;
    presc_n = tick ? '0 : presc + 1'b1;
    units_n = tick ? units + 16'd1 : units;
    beeps_n = beeps;
    case (state)
      IDLE: begin
        presc_n = '0;
        units_n = '0;
        if (game_over) begin
          state_n = GO_ON;
          beeps_n = 4'd1;
        end else if (food_eaten) begin
          state_n = EAT_ON;
        end
      end
      EAT_ON: begin
        // game_over preempts the food beep; food_eaten retriggers it
        if (game_over) begin
          state_n = GO_ON;
          beeps_n = 4'd1;
          presc_n = '0;
          units_n = '0;
        end else if (food_eaten) begin
          presc_n = '0;
          units_n = '0;
        end else if (done) begin
          state_n = IDLE;
          units_n = '0;
        end
      end
      GO_ON: begin
        if (done) begin
          units_n = '0;
          if (beeps == 4'(GO_BEEPS)) begin
            state_n = IDLE;
            beeps_n = '0;
          end else begin
            state_n = GO_OFF;
          end
        end
      end
      GO_OFF: begin
        if (done) begin
          units_n = '0;
          state_n = GO_ON;
          beeps_n = beeps + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        presc_n = '0;
        units_n = '0;
        beeps_n = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so an event shows up one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      units <= '0;
      beeps <= '0;
      Alarm <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      units <= units_n;
      beeps <= beeps_n;
      Alarm <= ((state_n == EAT_ON) || (state_n == GO_ON)) && !mute;
      busy  <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed run-length vectors for alarm_sequencer with small timing parameters,
// plus hand-written sequences for reset mid-pattern and total pattern length.
module tb_alarm_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic food_eaten = 1'b0;
  logic game_over = 1'b0;
  logic mute = 1'b0;
  logic Alarm, busy;

  int checks = 0;
  int errors = 0;

  alarm_sequencer #(
    .TICK_DIV(4), .EAT_ON_MS(3), .GO_ON_MS(5), .GO_OFF_MS(2), .GO_BEEPS(3)
  ) dut (
    .clk(clk), .reset(reset), .food_eaten(food_eaten), .game_over(game_over),
    .mute(mute), .Alarm(Alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulses are driven in the first cycle of a row only; mute/reset apply to the whole row.
  // Expected outputs are checked after each of the row's len edges.
  typedef struct {
    logic food;
    logic go;
    logic mte;
    logic rst;
    int   len;
    logic alarm;
    logic bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic f, input logic g, input logic m, input logic r,
                              input int n, input logic a, input logic b);
    vec_t v;
    v.food = f; v.go = g; v.mte = m; v.rst = r; v.len = n; v.alarm = a; v.bsy = b;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic f, input logic g, input logic m, input logic r);
    @(negedge clk);
    food_eaten = f;
    game_over  = g;
    mute       = m;
    reset      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic a, input logic b);
    checks++;
    if (Alarm !== a || busy !== b) begin
      errors++;
      $display("FAIL %s row/cycle %0d: Alarm=%b busy=%b, expected Alarm=%b busy=%b",
               name, idx, Alarm, busy, a, b);
    end
  endtask

  task automatic go_pattern(input logic f, input logic m);
    logic a;
    a = !m;
    add(f, 1, m, 0, 20, a, 1);
    add(0, 0, m, 0, 8, 0, 1);
    add(0, 0, m, 0, 20, a, 1);
    add(0, 0, m, 0, 8, 0, 1);
    add(0, 0, m, 0, 20, a, 1);
    add(0, 0, 0, 0, 3, 0, 0);
  endtask

  int cnt;

  initial begin
    // reset and idle
    add(0, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 3, 0, 0);
    // single food beep: 12 cycles
    add(1, 0, 0, 0, 12, 1, 1);
    add(0, 0, 0, 0, 4, 0, 0);
    // plain game over: 20/8/20/8/20
    go_pattern(0, 0);
    // retrigger five cycles in: 5 + 12 high
    add(1, 0, 0, 0, 5, 1, 1);
    add(1, 0, 0, 0, 12, 1, 1);
    add(0, 0, 0, 0, 3, 0, 0);
    // food then game over preempting; later food pulses ignored
    add(1, 0, 0, 0, 4, 1, 1);
    add(0, 1, 0, 0, 20, 1, 1);
    add(0, 0, 0, 0, 8, 0, 1);
    add(1, 0, 0, 0, 10, 1, 1);
    add(1, 0, 0, 0, 10, 1, 1);
    add(0, 0, 0, 0, 4, 0, 1);
    add(0, 1, 0, 0, 4, 0, 1);
    add(0, 0, 0, 0, 20, 1, 1);
    add(0, 0, 0, 0, 3, 0, 0);
    // simultaneous food and game over
    go_pattern(1, 0);
    // muted game over keeps busy profile
    go_pattern(0, 1);
    // mute during food beep, one-cycle latency visible as immediate drop after edge
    add(1, 0, 0, 0, 4, 1, 1);
    add(0, 0, 1, 0, 4, 0, 1);
    add(0, 0, 0, 0, 4, 1, 1);
    add(0, 0, 0, 0, 2, 0, 0);
    // new pattern immediately after busy falls
    add(1, 0, 0, 0, 12, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 12, 1, 1);
    add(0, 0, 0, 0, 2, 0, 0);
    // event coinciding with reset is dropped
    add(1, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 3, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].len; c++) begin
        step((c == 0) ? tbl[i].food : 1'b0, (c == 0) ? tbl[i].go : 1'b0, tbl[i].mte, tbl[i].rst);
        check("table", i, tbl[i].alarm, tbl[i].bsy);
      end
    end

    // reset one cycle in the middle of a game-over pattern
    step(0, 1, 0, 0);
    for (int c = 0; c < 24; c++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("reset_mid", 0, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    check("reset_idle", 0, 1'b0, 1'b0);
    step(1, 0, 0, 0);
    cnt = 0;
    while (Alarm === 1'b1 && cnt < 40) begin
      cnt++;
      step(0, 0, 0, 0);
    end
    checks++;
    if (cnt != 12) begin
      errors++;
      $display("FAIL food_after_reset: beep %0d cycles, expected 12", cnt);
    end
    step(0, 0, 0, 0);

    // total busy time of a game-over pattern, bounded wait
    step(0, 1, 0, 0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      step(0, 0, 0, 0);
    end
    checks++;
    if (cnt != 76) begin
      errors++;
      $display("FAIL go_busy_len: busy %0d cycles, expected 76", cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
